// File: rtl/ram_arb_pkg.sv
// Shared encodings and default widths for the two-port RAM arbiter.
// Used by the round-robin core and by the top-level mux.
package ram_arb_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    // A read grant remembered for one cycle until the RAM returns data.
    typedef struct packed {
        logic valid;
        logic side;
    } rd_tag_t;

    // The burst counter must be at least one bit wide, even when MAX_BURST is 1.
    function automatic int cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with bounded burst ownership.
// Produces the grant vector and the winning side every cycle.
module rr_arb2 #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       win_valid,
    output logic       win_side
);
    import ram_arb_pkg::*;

    localparam int              CNT_W   = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             last_win_q, last_win_d;
    logic             owned;
    logic             owner_side;

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        owned      = (state_q != ST_IDLE);
        owner_side = (state_q == ST_OWN_B) ? SIDE_B : SIDE_A;
        win_valid  = rst_n & (|req);
        win_side   = SIDE_A;
        gnt        = 2'b00;

        if (req == 2'b10) begin
            win_side = SIDE_B;
        end else if (req == 2'b11) begin
            if (!owned)
                win_side = ~last_win_q;
            else if (burst_q < CNT_MAX)
                win_side = owner_side;
            else
                win_side = ~owner_side;
        end

        if (win_valid)
            gnt[win_side] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        last_win_d = last_win_q;

        if (!win_valid) begin
            state_d = ST_IDLE;
            burst_d = '0;
        end else if (owned && (win_side == owner_side)) begin
            // A lone owner at the limit keeps going with a fresh count.
            burst_d = (burst_q == CNT_MAX) ? '0 : burst_q + CNT_ONE;
        end else begin
            state_d    = (win_side == SIDE_B) ? ST_OWN_B : ST_OWN_A;
            burst_d    = '0;
            last_win_d = win_side;
        end
    end

    // NOTE: reset is synchronous, so rst_n is tested inside the clocked block rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            burst_q    <= '0;
            last_win_q <= SIDE_B;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            burst_q    <= burst_d;
            last_win_q <= last_win_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between requesters A and B: arbitration core,
// RAM pin mux with hold-when-idle, and one-cycle read-data return routing.
module ram_port_arbiter #(
    parameter int DATA_W    = ram_arb_pkg::DATA_W,
    parameter int ADDR_W    = ram_arb_pkg::ADDR_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);
    import ram_arb_pkg::*;

    logic [1:0]        gnt;
    logic              win_valid;
    logic              win_side;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_data_q;
    rd_tag_t           rd_tag_q, rd_tag_d;
    logic              a_hit, b_hit;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    rr_arb2 #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({b_req, a_req}),
        .gnt       (gnt),
        .win_valid (win_valid),
        .win_side  (win_side)
    );

    assign a_gnt = gnt[0];
    assign b_gnt = gnt[1];

    always_comb begin
        sel_we   = (win_side == SIDE_B) ? b_we    : a_we;
        sel_addr = (win_side == SIDE_B) ? b_addr  : a_addr;
        sel_data = (win_side == SIDE_B) ? b_wdata : a_wdata;

        rd_tag_d.valid = win_valid & ~sel_we;
        rd_tag_d.side  = win_side;

        // Idle cycles replay the last address/data so the RAM pins do not toggle.
        ram_we   = win_valid & sel_we;
        ram_addr = !rst_n ? '0 : (win_valid ? sel_addr : ram_addr_q);
        ram_data = !rst_n ? '0 : (win_valid ? sel_data : ram_data_q);

        a_hit    = rst_n & rd_tag_q.valid & (rd_tag_q.side == SIDE_A);
        b_hit    = rst_n & rd_tag_q.valid & (rd_tag_q.side == SIDE_B);
        a_rvalid = a_hit;
        b_rvalid = b_hit;
        a_rdata  = !rst_n ? '0 : (a_hit ? ram_q : a_rdata_q);
        b_rdata  = !rst_n ? '0 : (b_hit ? ram_q : b_rdata_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_addr_q <= '0;
            ram_data_q <= '0;
            rd_tag_q   <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            if (win_valid) begin
                ram_addr_q <= sel_addr;
                ram_data_q <= sel_data;
            end
            rd_tag_q <= rd_tag_d;
            if (a_hit)
                a_rdata_q <= ram_q;
            if (b_hit)
                b_rdata_q <= ram_q;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Table-driven bench for ram_port_arbiter with a behavioural 64x8 single-port RAM,
// followed by a hand-written lone-burst sequence and continuous grant invariants.
module tb_ram_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_req, a_we, a_gnt, a_rvalid;
    logic [5:0] a_addr;
    logic [7:0] a_wdata, a_rdata;
    logic       b_req, b_we, b_gnt, b_rvalid;
    logic [5:0] b_addr;
    logic [7:0] b_wdata, b_rdata;
    logic [7:0] ram_data, ram_q;
    logic [5:0] ram_addr;
    logic       ram_we;

    int n_cmp  = 0;
    int n_fail = 0;
    logic inv_en = 1'b0;

    ram_port_arbiter #(
        .DATA_W    (8),
        .ADDR_W    (6),
        .MAX_BURST (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .ram_data (ram_data),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_q    (ram_q)
    );

    // Single-port RAM: one access per cycle, q valid the cycle after addr is sampled.
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
    } req_t;

    typedef struct packed {
        logic       ga;
        logic       gb;
        logic       we;
        logic [5:0] addr;
        logic       arv;
        logic [7:0] ard;
        logic       brv;
        logic [7:0] brd;
    } exp_t;

    typedef struct packed {
        logic rst_n;
        req_t a;
        req_t b;
        exp_t x;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic req_t rd(input int a);
        req_t r;
        r.req = 1'b1; r.we = 1'b0; r.addr = 6'(a); r.wdata = 8'h00;
        return r;
    endfunction

    function automatic req_t wr(input int a, input int d);
        req_t r;
        r.req = 1'b1; r.we = 1'b1; r.addr = 6'(a); r.wdata = 8'(d);
        return r;
    endfunction

    function automatic req_t nr();
        req_t r;
        r = '0;
        return r;
    endfunction

    function automatic exp_t e(input int ga, input int gb, input int we, input int addr,
                               input int arv, input int ard, input int brv, input int brd);
        exp_t x;
        x.ga = 1'(ga); x.gb = 1'(gb); x.we = 1'(we); x.addr = 6'(addr);
        x.arv = 1'(arv); x.ard = 8'(ard); x.brv = 1'(brv); x.brd = 8'(brd);
        return x;
    endfunction

    task automatic add(input int rst, input req_t a, input req_t b, input exp_t x);
        vec_t v;
        v.rst_n = 1'(rst); v.a = a; v.b = b; v.x = x;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input req_t a, input req_t b);
        rst_n = r;
        a_req = a.req; a_we = a.we; a_addr = a.addr; a_wdata = a.wdata;
        b_req = b.req; b_we = b.we; b_addr = b.addr; b_wdata = b.wdata;
    endtask

    // Grant safety rules, checked every cycle while stimulus is active.
    always @(negedge clk) begin
        if (inv_en) begin
            check("inv_one_hot_gnt", 32'(a_gnt & b_gnt), 32'd0);
            check("inv_a_gnt_has_req", 32'(a_gnt & ~a_req), 32'd0);
            check("inv_b_gnt_has_req", 32'(b_gnt & ~b_req), 32'd0);
            check("inv_we_has_gnt", 32'(ram_we & ~(a_gnt | b_gnt)), 32'd0);
        end
    end

    initial begin
        vec_t v;
        int   got;

        drive(1'b0, nr(), nr());

        //        rst  A            B               gA gB we adr aRv aRd  bRv bRd
        // Reset with both requesting.
        add(0, wr(5, 8'h11), wr(6, 8'h22), e(0, 0, 0, 0,  0, 8'h00, 0, 8'h00));
        add(0, wr(5, 8'h11), wr(6, 8'h22), e(0, 0, 0, 0,  0, 8'h00, 0, 8'h00));
        // Lone A writes 01..05 to 0..4, reads 0..2, then idles (addr held, rdata held).
        add(1, wr(0, 8'h01), nr(),         e(1, 0, 1, 0,  0, 8'h00, 0, 8'h00));
        add(1, wr(1, 8'h02), nr(),         e(1, 0, 1, 1,  0, 8'h00, 0, 8'h00));
        add(1, wr(2, 8'h03), nr(),         e(1, 0, 1, 2,  0, 8'h00, 0, 8'h00));
        add(1, wr(3, 8'h04), nr(),         e(1, 0, 1, 3,  0, 8'h00, 0, 8'h00));
        add(1, wr(4, 8'h05), nr(),         e(1, 0, 1, 4,  0, 8'h00, 0, 8'h00));
        add(1, rd(0),        nr(),         e(1, 0, 0, 0,  0, 8'h00, 0, 8'h00));
        add(1, rd(1),        nr(),         e(1, 0, 0, 1,  1, 8'h01, 0, 8'h00));
        add(1, rd(2),        nr(),         e(1, 0, 0, 2,  1, 8'h02, 0, 8'h00));
        add(1, nr(),         nr(),         e(0, 0, 0, 2,  1, 8'h03, 0, 8'h00));
        add(1, nr(),         nr(),         e(0, 0, 0, 2,  0, 8'h03, 0, 8'h00));
        // Reset again so the tie starts from last_win=B.
        add(0, rd(0),        rd(1),        e(0, 0, 0, 0,  0, 8'h00, 0, 8'h00));
        add(0, rd(0),        rd(1),        e(0, 0, 0, 0,  0, 8'h00, 0, 8'h00));
        // Continuous tie: A,A,A,A,B,B,B,B,A.
        add(1, rd(0),        rd(1),        e(1, 0, 0, 0,  0, 8'h00, 0, 8'h00));
        add(1, rd(0),        rd(1),        e(1, 0, 0, 0,  1, 8'h01, 0, 8'h00));
        add(1, rd(0),        rd(1),        e(1, 0, 0, 0,  1, 8'h01, 0, 8'h00));
        add(1, rd(0),        rd(1),        e(1, 0, 0, 0,  1, 8'h01, 0, 8'h00));
        add(1, rd(0),        rd(1),        e(0, 1, 0, 1,  1, 8'h01, 0, 8'h00));
        add(1, rd(0),        rd(1),        e(0, 1, 0, 1,  0, 8'h01, 1, 8'h02));
        add(1, rd(0),        rd(1),        e(0, 1, 0, 1,  0, 8'h01, 1, 8'h02));
        add(1, rd(0),        rd(1),        e(0, 1, 0, 1,  0, 8'h01, 1, 8'h02));
        add(1, rd(0),        rd(1),        e(1, 0, 0, 0,  0, 8'h01, 1, 8'h02));
        // Interleaved reads: A addr 3, B addr 4, routed to the right side.
        add(1, rd(3),        rd(4),        e(1, 0, 0, 3,  1, 8'h01, 0, 8'h02));
        add(1, nr(),         rd(4),        e(0, 1, 0, 4,  1, 8'h04, 0, 8'h02));
        add(1, nr(),         nr(),         e(0, 0, 0, 4,  0, 8'h04, 1, 8'h05));
        add(1, nr(),         nr(),         e(0, 0, 0, 4,  0, 8'h04, 0, 8'h05));
        // B writes AA to 63, A reads 63 the next cycle.
        add(1, nr(),         wr(63, 8'hAA), e(0, 1, 1, 63, 0, 8'h04, 0, 8'h05));
        add(1, rd(63),       nr(),         e(1, 0, 0, 63, 0, 8'h04, 0, 8'h05));
        add(1, nr(),         nr(),         e(0, 0, 0, 63, 1, 8'hAA, 0, 8'h05));
        // Read granted, then reset: no rvalid, state back to IDLE with A winning the tie.
        add(1, rd(0),        nr(),         e(1, 0, 0, 0,  0, 8'hAA, 0, 8'h05));
        add(0, nr(),         nr(),         e(0, 0, 0, 0,  0, 8'h00, 0, 8'h00));
        add(1, nr(),         nr(),         e(0, 0, 0, 0,  0, 8'h00, 0, 8'h00));
        add(1, rd(1),        rd(2),        e(1, 0, 0, 1,  0, 8'h00, 0, 8'h00));
        add(1, nr(),         nr(),         e(0, 0, 0, 1,  1, 8'h02, 0, 8'h00));

        inv_en = 1'b1;
        foreach (vecs[i]) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            drive(v.rst_n, v.a, v.b);
            @(negedge clk);
            check($sformatf("r%0d_a_gnt", i),    32'(a_gnt),    32'(v.x.ga));
            check($sformatf("r%0d_b_gnt", i),    32'(b_gnt),    32'(v.x.gb));
            check($sformatf("r%0d_ram_we", i),   32'(ram_we),   32'(v.x.we));
            check($sformatf("r%0d_ram_addr", i), 32'(ram_addr), 32'(v.x.addr));
            check($sformatf("r%0d_a_rvalid", i), 32'(a_rvalid), 32'(v.x.arv));
            check($sformatf("r%0d_a_rdata", i),  32'(a_rdata),  32'(v.x.ard));
            check($sformatf("r%0d_b_rvalid", i), 32'(b_rvalid), 32'(v.x.brv));
            check($sformatf("r%0d_b_rdata", i),  32'(b_rdata),  32'(v.x.brd));
            if (!v.rst_n)
                check($sformatf("r%0d_ram_data_rst", i), 32'(ram_data), 32'd0);
        end

        // Lone B bursts past MAX_BURST: it keeps the grant every cycle.
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            drive(1'b1, nr(), wr(10 + k, 8'hB0 + k));
            @(negedge clk);
            check($sformatf("seq_lone_b_gnt%0d", k), 32'(b_gnt), 32'd1);
            check($sformatf("seq_lone_b_data%0d", k), 32'(ram_data), 32'(8'hB0 + k));
        end

        // Read back addr 12; rvalid must arrive on the very next cycle.
        @(posedge clk);
        #1;
        drive(1'b1, nr(), rd(12));
        @(negedge clk);
        check("seq_rd_gnt", 32'(b_gnt), 32'd1);
        check("seq_rd_addr", 32'(ram_addr), 32'd12);
        got = 0;
        for (int k = 0; k < 4 && got == 0; k++) begin
            @(posedge clk);
            #1;
            drive(1'b1, nr(), nr());
            @(negedge clk);
            if (b_rvalid) begin
                got = 1;
                check("seq_rd_latency", 32'(k), 32'd0);
                check("seq_rd_data", 32'(b_rdata), 32'hB2);
                check("seq_rd_a_quiet", 32'(a_rvalid), 32'd0);
            end
        end
        check("seq_rvalid_seen", 32'(got), 32'd1);

        inv_en = 1'b0;
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
